// File: rtl/dft_bfly_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dft_bfly_sched_if
// Brief    : Control, read-issue and write-back bundle of the DFT butterfly
//            sequencer. Abort signals exist only with DFT_SCHED_ABORT_EN.
// Revision : 1.0
// ============================================================================
interface dft_bfly_sched_if #(
  parameter int LOG2N = 3
);
  logic             i_start;
  logic             i_hold;
`ifdef DFT_SCHED_ABORT_EN
  logic             i_abort;
  logic             o_aborted;
`endif
  logic             o_busy;
  logic             o_done;
  logic             o_rd_en;
  logic [LOG2N-1:0] o_rd_addr_a;
  logic [LOG2N-1:0] o_rd_addr_b;
  logic [LOG2N-2:0] o_tw_idx;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a;
  logic [LOG2N-1:0] o_wr_addr_b;
  logic [LOG2N-1:0] o_stage;

  modport slave (
    input  i_start, i_hold,
`ifdef DFT_SCHED_ABORT_EN
    input  i_abort,
    output o_aborted,
`endif
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );

  modport master (
    output i_start, i_hold,
`ifdef DFT_SCHED_ABORT_EN
    output i_abort,
    input  o_aborted,
`endif
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );
endinterface
`default_nettype wire

// File: rtl/dft_bfly_sched.sv
`default_nettype none
// ============================================================================
// Module   : dft_bfly_sched
// Brief    : In-place radix-2 DIT DFT sequencer: one butterfly issue per cycle,
//            pipeline drained between stages. Option macro: DFT_SCHED_ABORT_EN.
// Revision : 1.0
// ============================================================================
module dft_bfly_sched #(
  parameter int N_PTS    = 8,
  parameter int LOG2N    = 3,
  parameter int BFLY_LAT = 1
) (
  input  wire             i_CLK,
  input  wire             i_RESET,
  dft_bfly_sched_if.slave bus
);

  localparam int PIPE_LAT     = 1 + BFLY_LAT;
  localparam int K_LAST_I     = N_PTS / 2 - 1;
  localparam int STAGE_LAST_I = LOG2N - 1;
  localparam int ONE_I        = 1;
  localparam logic [LOG2N-2:0] K_LAST     = K_LAST_I[LOG2N-2:0];
  localparam logic [LOG2N-1:0] STAGE_LAST = STAGE_LAST_I[LOG2N-1:0];
  localparam logic [LOG2N-1:0] ONE        = ONE_I[LOG2N-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LOG2N-2:0] r_k;
  logic [LOG2N-1:0] r_stage;
  logic [PIPE_LAT-1:0] r_pv;
  logic [LOG2N-1:0] r_pa [PIPE_LAT];
  logic [LOG2N-1:0] r_pb [PIPE_LAT];

  logic             w_hold;
  logic             w_abort;
  logic             w_run;
  logic             w_k_last;
  logic             w_drain_empty;
  logic [LOG2N-1:0] w_k_ext;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [LOG2N-2:0] w_tw;

  assign w_hold   = bus.i_hold;
  assign w_run    = (r_state == S_RUN);
  assign w_k_last = (r_k == K_LAST);

`ifdef DFT_SCHED_ABORT_EN
  logic r_aborted;

  assign w_abort       = bus.i_abort && (r_state == S_RUN || r_state == S_DRAIN);
  assign bus.o_aborted = r_aborted;

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) r_aborted <= 1'b0;
    else          r_aborted <= w_abort;
  end
`else
  assign w_abort = 1'b0;
`endif

  // Butterfly k of stage s: groups of 2*half points, leg b sits half above leg a.
  assign w_k_ext = {1'b0, r_k};
  assign w_half  = ONE << r_stage;
  assign w_pos   = w_k_ext & (w_half - ONE);
  assign w_grp   = w_k_ext >> r_stage;
  assign w_a     = ((w_grp << r_stage) << 1) | w_pos;
  assign w_b     = w_a | w_half;
  assign w_tw    = w_pos[LOG2N-2:0] << (STAGE_LAST - r_stage);

  // The stage may end once only the oldest slot still holds a write: that
  // write is presented in this very cycle, so the next read cannot overtake it.
  generate
    if (PIPE_LAT == 1) begin : g_drain_shallow
      assign w_drain_empty = 1'b1;
    end else begin : g_drain_deep
      assign w_drain_empty = ~|r_pv[PIPE_LAT-2:0];
    end
  endgenerate

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_IDLE;
    end else if (!w_hold) begin
      case (r_state)
        S_IDLE:  if (bus.i_start) w_state_next = S_RUN;
        S_RUN:   if (w_k_last) w_state_next = S_DRAIN;
        S_DRAIN: if (w_drain_empty)
                   w_state_next = (r_stage == STAGE_LAST) ? S_DONE : S_RUN;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_k     <= '0;
      r_stage <= '0;
    end else if (w_abort) begin
      r_k     <= '0;
      r_stage <= '0;
    end else if (!w_hold) begin
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_k     <= '0;
          r_stage <= '0;
        end
        S_RUN:   r_k <= w_k_last ? '0 : r_k + 1'b1;
        S_DRAIN: if (w_drain_empty && r_stage != STAGE_LAST) r_stage <= r_stage + 1'b1;
        S_DONE:  r_stage <= '0;
        default: r_k <= '0;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else if (w_abort) begin
      r_pv <= '0;
    end else if (!w_hold) begin
      r_pv[0] <= w_run;
      r_pa[0] <= w_a;
      r_pb[0] <= w_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign bus.o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_rd_en     = w_run && !w_hold;
  assign bus.o_rd_addr_a = w_run ? w_a  : '0;
  assign bus.o_rd_addr_b = w_run ? w_b  : '0;
  assign bus.o_tw_idx    = w_run ? w_tw : '0;
  assign bus.o_wr_en     = r_pv[PIPE_LAT-1] && !w_hold;
  assign bus.o_wr_addr_a = r_pa[PIPE_LAT-1];
  assign bus.o_wr_addr_b = r_pb[PIPE_LAT-1];
  assign bus.o_stage     = r_stage;

endmodule
`default_nettype wire

// File: tb/tb_dft_bfly_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dft_bfly_sched
// Brief    : Scoreboard bench for dft_bfly_sched (N=8, BFLY_LAT 1 and 0).
// Revision : 1.0
// ============================================================================
module tb_dft_bfly_sched;

  localparam int N_PTS = 8;
  localparam int LOG2N = 3;

  typedef struct { int a; int b; int tw; int s; } rd_t;
  typedef struct { int a; int b; int due; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic abort = 1'b0;
  int   sel = 1;
  int   checks = 0;
  int   errors = 0;

  rd_t rq[$];
  wr_t wq[$];

  always #5 clk = ~clk;

  dft_bfly_sched_if #(.LOG2N(LOG2N)) bus1 ();
  dft_bfly_sched_if #(.LOG2N(LOG2N)) bus0 ();

  assign bus1.i_start = start && (sel == 1);
  assign bus1.i_hold  = hold  && (sel == 1);
  assign bus0.i_start = start && (sel == 0);
  assign bus0.i_hold  = hold  && (sel == 0);
`ifdef DFT_SCHED_ABORT_EN
  assign bus1.i_abort = abort && (sel == 1);
  assign bus0.i_abort = abort && (sel == 0);
`endif

  dft_bfly_sched #(.N_PTS(N_PTS), .LOG2N(LOG2N), .BFLY_LAT(1)) dut1 (
    .i_CLK(clk), .i_RESET(rst_n), .bus(bus1.slave)
  );
  dft_bfly_sched #(.N_PTS(N_PTS), .LOG2N(LOG2N), .BFLY_LAT(0)) dut0 (
    .i_CLK(clk), .i_RESET(rst_n), .bus(bus0.slave)
  );

  logic busy, done, rd_en, wr_en;
  logic [LOG2N-1:0] rd_a, rd_b, wr_a, wr_b, stage;
  logic [LOG2N-2:0] tw;
  logic aborted;

  always_comb begin
    busy = bus1.o_busy;  done = bus1.o_done;  rd_en = bus1.o_rd_en;
    rd_a = bus1.o_rd_addr_a; rd_b = bus1.o_rd_addr_b; tw = bus1.o_tw_idx;
    wr_en = bus1.o_wr_en; wr_a = bus1.o_wr_addr_a; wr_b = bus1.o_wr_addr_b;
    stage = bus1.o_stage;
    if (sel == 0) begin
      busy = bus0.o_busy;  done = bus0.o_done;  rd_en = bus0.o_rd_en;
      rd_a = bus0.o_rd_addr_a; rd_b = bus0.o_rd_addr_b; tw = bus0.o_tw_idx;
      wr_en = bus0.o_wr_en; wr_a = bus0.o_wr_addr_a; wr_b = bus0.o_wr_addr_b;
      stage = bus0.o_stage;
    end
`ifdef DFT_SCHED_ABORT_EN
    aborted = (sel == 0) ? bus0.o_aborted : bus1.o_aborted;
`else
    aborted = 1'b0;
`endif
  end

  // Expected issue order: classic group/position nested loops per stage.
  task automatic build_expected();
    rd_t e;
    int half;
    rq.delete();
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int g = 0; g < N_PTS / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          e.a  = g * 2 * half + p;
          e.b  = e.a + half;
          e.tw = p * (N_PTS / (2 * half));
          e.s  = s;
          rq.push_back(e);
        end
      end
    end
  endtask

  task automatic run_check(input int dsel, input int plat, input int hold_at,
                           input int hold_len, input string tag);
    int  done_exp;
    int  nh;
    int  prev_stage;
    int  first_rd;
    bit  held_prev;
    bit  exp_busy;
    logic [LOG2N-1:0] p_rd_a, p_wr_a;
    rd_t e;
    wr_t w;
    done_exp   = 1 + LOG2N * (N_PTS / 2 + plat) + hold_len;
    nh         = 0;
    prev_stage = -1;
    first_rd   = -1;
    held_prev  = 1'b0;
    p_rd_a     = '0;
    p_wr_a     = '0;
    sel = dsel;
    build_expected();
    wq.delete();
    for (int c = 0; c <= done_exp + 3; c++) begin
      @(negedge clk);
      start = (c == 0);
      hold  = (c >= hold_at) && (c < hold_at + hold_len);
      #1;
      exp_busy = (c >= 1) && (c < done_exp);
      checks++;
      if (busy !== exp_busy)
        $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, busy, exp_busy);
      if (busy !== exp_busy) errors++;
      checks++;
      if (done !== (c == done_exp)) begin
        errors++;
        $display("FAIL %s done c=%0d: got %b expected %b", tag, c, done, (c == done_exp));
      end
      if (hold) begin
        checks++;
        if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
          errors++;
          $display("FAIL %s hold strobes c=%0d: got rd=%b wr=%b expected 0", tag, c, rd_en, wr_en);
        end
        if (held_prev) begin
          checks++;
          if (rd_a !== p_rd_a || wr_a !== p_wr_a) begin
            errors++;
            $display("FAIL %s hold addr c=%0d: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     tag, c, rd_a, wr_a, p_rd_a, p_wr_a);
          end
        end
      end
      if (rd_en === 1'b1) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra read c=%0d: got a=%0d expected none", tag, c, rd_a);
        end else begin
          e = rq.pop_front();
          if (first_rd < 0) first_rd = c;
          checks++;
          if (int'(rd_a) !== e.a || int'(rd_b) !== e.b || int'(tw) !== e.tw || int'(stage) !== e.s) begin
            errors++;
            $display("FAIL %s read c=%0d: got (%0d,%0d) tw %0d s %0d expected (%0d,%0d) tw %0d s %0d",
                     tag, c, rd_a, rd_b, tw, stage, e.a, e.b, e.tw, e.s);
          end
          if (e.s != prev_stage) begin
            checks++;
            if (wq.size() != 0) begin
              errors++;
              $display("FAIL %s stage overlap c=%0d: got %0d pending writes expected 0", tag, c, wq.size());
            end
            prev_stage = e.s;
          end
          w.a = e.a; w.b = e.b; w.due = nh + plat;
          wq.push_back(w);
        end
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL %s extra write c=%0d: got a=%0d expected none", tag, c, wr_a);
        end else begin
          w = wq.pop_front();
          if (int'(wr_a) !== w.a || int'(wr_b) !== w.b || nh !== w.due) begin
            errors++;
            $display("FAIL %s write c=%0d: got (%0d,%0d) at %0d expected (%0d,%0d) at %0d",
                     tag, c, wr_a, wr_b, nh, w.a, w.b, w.due);
          end
        end
      end else if (!hold && wq.size() != 0) begin
        checks++;
        if (wq[0].due <= nh) begin
          errors++;
          $display("FAIL %s missing write c=%0d: got none expected (%0d,%0d)", tag, c, wq[0].a, wq[0].b);
          void'(wq.pop_front());
        end
      end
      if (!hold) nh++;
      held_prev = hold;
      p_rd_a = rd_a;
      p_wr_a = wr_a;
    end
    start = 1'b0;
    hold  = 1'b0;
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL %s leftovers: got rd=%0d wr=%0d expected 0", tag, rq.size(), wq.size());
    end
    checks++;
    if (first_rd != 1) begin
      errors++;
      $display("FAIL %s first read cycle: got %0d expected 1", tag, first_rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus1.o_busy, bus1.o_done, bus1.o_rd_en, bus1.o_rd_addr_a, bus1.o_rd_addr_b, bus1.o_tw_idx,
         bus1.o_wr_en, bus1.o_wr_addr_a, bus1.o_wr_addr_b, bus1.o_stage} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got nonzero expected all 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    sel = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b, stage} !== '0) begin
      errors++;
      $display("FAIL async reset: got busy=%b rd=%b wr=%b expected all 0", busy, rd_en, wr_en);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post-reset idle c=%0d: got done=%b busy=%b expected 0", c, done, busy);
      end
    end
    run_check(1, 2, 1000, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int dones[$];
    sel = 1;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      start = (c <= 39);
      #1;
      if (done === 1'b1) dones.push_back(c);
      if (c == 19 || c == 20 || c == 40) begin
        checks++;
        if (rd_en !== 1'b0) begin
          errors++;
          $display("FAIL b2b read in gap c=%0d: got %b expected 0", c, rd_en);
        end
      end
      if (c == 21) begin
        checks++;
        if (rd_en !== 1'b1) begin
          errors++;
          $display("FAIL b2b restart c=21: got rd_en=%b expected 1", rd_en);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones.size() != 2 || dones[0] != 19 || dones[1] != 39) begin
      errors++;
      $display("FAIL b2b done cycles: got %0d pulses first %0d expected 2 pulses at 19,39",
               dones.size(), (dones.size() > 0) ? dones[0] : -1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b final idle: got busy=%b expected 0", busy);
    end
  endtask

`ifdef DFT_SCHED_ABORT_EN
  task automatic test_abort();
    sel = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 8);
      #1;
      checks++;
      if (aborted !== (c == 9)) begin
        errors++;
        $display("FAIL abort pulse c=%0d: got %b expected %b", c, aborted, (c == 9));
      end
      if (c >= 9) begin
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
          errors++;
          $display("FAIL abort idle c=%0d: got wr=%b done=%b busy=%b rd=%b expected 0",
                   c, wr_en, done, busy, rd_en);
        end
      end
    end
    abort = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    run_check(1, 2, 1000, 0, "lat1");
    run_check(1, 2, 9, 3, "hold");
    test_async_reset();
    run_check(0, 1, 1000, 0, "lat0");
    test_back_to_back();
`ifdef DFT_SCHED_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
